// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 16x oversampling, 2-of-3 majority per bit, baud chosen per frame.
// Stop decision is taken at mid-stop so back-to-back frames with no idle gap are received.
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  localparam int unsigned DIV_0 = CLK_FREQ / (9600 * 16);
  localparam int unsigned DIV_1 = CLK_FREQ / (19200 * 16);
  localparam int unsigned DIV_2 = CLK_FREQ / (38400 * 16);
  localparam int unsigned DIV_3 = CLK_FREQ / (57600 * 16);
  localparam int unsigned DIV_4 = CLK_FREQ / (115200 * 16);
  localparam int unsigned CNT_W = (DIV_0 > 1) ? $clog2(DIV_0) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             rx_s1, rx_s2, rx_s3;
  logic [2:0]       baud_lat;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_m1;
  logic [3:0]       tick_idx;
  logic [2:0]       bit_idx;
  logic [1:0]       samp;
  logic [7:0]       shift_reg;
  logic             rx_fall_c;
  logic             tick_c;
  logic             maj_c;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall_c = rx_s3 & ~rx_s2;

  // Divider terminal count for the baud latched at the start edge
  always_comb begin
    div_m1 = CNT_W'(DIV_4 - 1);
    case (baud_lat)
      3'd0:    div_m1 = CNT_W'(DIV_0 - 1);
      3'd1:    div_m1 = CNT_W'(DIV_1 - 1);
      3'd2:    div_m1 = CNT_W'(DIV_2 - 1);
      3'd3:    div_m1 = CNT_W'(DIV_3 - 1);
      default: div_m1 = CNT_W'(DIV_4 - 1);
    endcase
  end

  assign tick_c = (state != IDLE) && (div_cnt == div_m1);

  // Tick-9 sample is the live synchronized line; ticks 7 and 8 are held in samp
  assign maj_c = (samp[1] & samp[0]) | (samp[1] & rx_s2) | (samp[0] & rx_s2);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      baud_lat   <= 3'd0;
      div_cnt    <= '0;
      tick_idx   <= 4'd0;
      bit_idx    <= 3'd0;
      samp       <= 2'b00;
      shift_reg  <= 8'h00;
      rx_data    <= 8'h00;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        div_cnt  <= '0;
        tick_idx <= 4'd0;
        bit_idx  <= 3'd0;
        if (rx_fall_c) begin
          state      <= START;
          uart_state <= 1'b1;
          baud_lat   <= baud_set;
        end
      end else begin
        div_cnt <= tick_c ? '0 : div_cnt + 1'b1;
        if (tick_c) begin
          tick_idx <= tick_idx + 4'd1;
          if (tick_idx == 4'd7) samp[0] <= rx_s2;
          if (tick_idx == 4'd8) samp[1] <= rx_s2;
          case (state)
            START: begin
              if (tick_idx == 4'd9 && maj_c) begin
                state      <= IDLE;
                uart_state <= 1'b0;
              end else if (tick_idx == 4'd15) begin
                state <= DATA;
              end
            end
            DATA: begin
              if (tick_idx == 4'd9) shift_reg <= {maj_c, shift_reg[7:1]};
              if (tick_idx == 4'd15) begin
                bit_idx <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) state <= STOP;
              end
            end
            STOP: begin
              if (tick_idx == 4'd9) begin
                state      <= IDLE;
                uart_state <= 1'b0;
                if (maj_c) begin
                  rx_data <= shift_reg;
                  rx_done <= 1'b1;
                end else begin
                  frame_err <= 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomized self-checking bench for uart_byte_rx against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  localparam int unsigned CLK_FREQ = 3_686_400;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [2:0] baud_set;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  int vectors;
  int miscompares;

  int         done_cnt;
  int         err_cnt;
  int         both_cnt;
  logic [7:0] got[$];
  logic [7:0] exp_data;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .baud_set   (baud_set),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Record every output pulse cycle; a stretched pulse shows up as an extra entry
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (rx_done) begin
        done_cnt = done_cnt + 1;
        got.push_back(rx_data);
      end
      if (frame_err) err_cnt = err_cnt + 1;
      if (rx_done && frame_err) both_cnt = both_cnt + 1;
    end
  end

  // Cycles per bit from the baud table: 16 ticks of floor(CLK_FREQ / (16 * baud))
  function automatic int unsigned bit_cycles(input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      3'd0:    baud = 9600;
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      default: baud = 115200;
    endcase
    return 16 * (CLK_FREQ / (baud * 16));
  endfunction

  task automatic drive_bit(input logic v, input int unsigned n);
    uart_rx = v;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic [2:0] sel);
    int unsigned n;
    n = bit_cycles(sel);
    baud_set = sel;
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) drive_bit(b[i], n);
    drive_bit(stop, n);
  endtask

  task automatic idle(input int unsigned n);
    uart_rx = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    uart_rx   = 1'b1;
    baud_set  = 3'd4;
    repeat (3) @(negedge sys_clk);
    vectors++;
    if ({rx_data, rx_done, frame_err, uart_state} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h done=%b err=%b state=%b want 00 0 0 0",
               rx_data, rx_done, frame_err, uart_state);
    end
    #2 sys_rst_n = 1'b1;
    idle(20);
    vectors++;
    if ({rx_done, frame_err, uart_state} !== 3'b000 || done_cnt + err_cnt != 0) begin
      miscompares++;
      $display("FAIL reset_idle: got done=%b err=%b state=%b pulses=%0d want quiet",
               rx_done, frame_err, uart_state, done_cnt + err_cnt);
    end
  endtask

  task automatic test_single;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt; got.delete();
    baud_set = 3'd4;
    uart_rx = 1'b0;
    repeat (bit_cycles(3'd4) / 2) @(negedge sys_clk);
    vectors++;
    if (uart_state !== 1'b1) begin
      miscompares++;
      $display("FAIL single_busy: got uart_state=%b want 1", uart_state);
    end
    repeat (bit_cycles(3'd4) - bit_cycles(3'd4) / 2) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) drive_bit(i[0] ? 1'b0 : 1'b1, bit_cycles(3'd4));
    drive_bit(1'b1, bit_cycles(3'd4));
    idle(10);
    exp_data = 8'h55;
    vectors++;
    if (done_cnt - d0 != 1 || err_cnt != e0 || rx_data !== exp_data) begin
      miscompares++;
      $display("FAIL single_55: got done=%0d err=%0d data=%h want 1 0 %h",
               done_cnt - d0, err_cnt - e0, rx_data, exp_data);
    end
    vectors++;
    if (uart_state !== 1'b0) begin
      miscompares++;
      $display("FAIL single_idle: got uart_state=%b want 0", uart_state);
    end
  endtask

  task automatic test_back_to_back;
    int e0;
    e0 = err_cnt; got.delete();
    send_frame(8'hA3, 1'b1, 3'd0);
    send_frame(8'h0F, 1'b1, 3'd0);
    idle(10);
    exp_data = 8'h0F;
    vectors++;
    if (got.size() != 2 || err_cnt != e0) begin
      miscompares++;
      $display("FAIL b2b_count: got done=%0d err=%0d want 2 0", got.size(), err_cnt - e0);
    end else begin
      vectors++;
      if (got[0] !== 8'hA3 || got[1] !== 8'h0F) begin
        miscompares++;
        $display("FAIL b2b_data: got %h %h want a3 0f", got[0], got[1]);
      end
    end
    vectors++;
    if (rx_data !== exp_data) begin
      miscompares++;
      $display("FAIL b2b_final: got %h want %h", rx_data, exp_data);
    end
  endtask

  task automatic test_glitch;
    int d0, e0;
    int unsigned glen;
    d0 = done_cnt; e0 = err_cnt;
    glen = CLK_FREQ / 500_000;
    baud_set = 3'd4;
    drive_bit(1'b0, glen);
    drive_bit(1'b1, 10 - glen);
    vectors++;
    if (uart_state !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_start: got uart_state=%b want 1", uart_state);
    end
    idle(bit_cycles(3'd4) - 10);
    vectors++;
    if (uart_state !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_recover: got uart_state=%b want 0 within one bit", uart_state);
    end
    idle(bit_cycles(3'd4) * 12);
    vectors++;
    if (done_cnt != d0 || err_cnt != e0 || rx_data !== exp_data) begin
      miscompares++;
      $display("FAIL glitch_quiet: got done=%0d err=%0d data=%h want 0 0 %h",
               done_cnt - d0, err_cnt - e0, rx_data, exp_data);
    end
  endtask

  task automatic test_frame_err;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 3'd4);
    idle(bit_cycles(3'd4));
    vectors++;
    if (err_cnt - e0 != 1 || done_cnt != d0) begin
      miscompares++;
      $display("FAIL ferr_pulse: got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
    vectors++;
    if (rx_data !== exp_data || both_cnt != 0) begin
      miscompares++;
      $display("FAIL ferr_hold: got data=%h both=%0d want %h 0", rx_data, both_cnt, exp_data);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int unsigned n;
    int e0;
    b = 8'hF0;
    n = bit_cycles(3'd4);
    baud_set = 3'd4;
    e0 = err_cnt;
    drive_bit(1'b0, n);
    for (int i = 0; i < 4; i++) drive_bit(b[i], n);
    drive_bit(b[4], n / 2);
    vectors++;
    if (uart_state !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_busy: got uart_state=%b want 1", uart_state);
    end
    #2 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({rx_data, rx_done, frame_err, uart_state} !== 11'h000) begin
      miscompares++;
      $display("FAIL rstmid_async: got data=%h done=%b err=%b state=%b want 00 0 0 0",
               rx_data, rx_done, frame_err, uart_state);
    end
    exp_data = 8'h00;
    uart_rx = 1'b1;
    repeat (4) @(negedge sys_clk);
    #3 sys_rst_n = 1'b1;
    idle(n * 4);
    got.delete();
    send_frame(8'h81, 1'b1, 3'd4);
    idle(10);
    exp_data = 8'h81;
    vectors++;
    if (got.size() != 1 || err_cnt != e0 || rx_data !== exp_data) begin
      miscompares++;
      $display("FAIL rstmid_next: got done=%0d err=%0d data=%h want 1 0 %h",
               got.size(), err_cnt - e0, rx_data, exp_data);
    end
  endtask

  task automatic test_baud_change;
    logic [7:0] b;
    int unsigned n;
    int e0;
    b = 8'h5A;
    n = bit_cycles(3'd4);
    e0 = err_cnt;
    got.delete();
    baud_set = 3'd4;
    drive_bit(1'b0, n);
    drive_bit(b[0], n);
    drive_bit(b[1], n);
    drive_bit(b[2], n / 2);
    baud_set = 3'd0;
    drive_bit(b[2], n - n / 2);
    for (int i = 3; i < 8; i++) drive_bit(b[i], n);
    drive_bit(1'b1, n);
    idle(10);
    exp_data = 8'h5A;
    vectors++;
    if (got.size() != 1 || rx_data !== exp_data) begin
      miscompares++;
      $display("FAIL baudchg_frame: got done=%0d data=%h want 1 %h", got.size(), rx_data, exp_data);
    end
    send_frame(8'hC3, 1'b1, 3'd0);
    idle(10);
    exp_data = 8'hC3;
    vectors++;
    if (got.size() != 2 || rx_data !== exp_data || err_cnt != e0) begin
      miscompares++;
      $display("FAIL baudchg_next: got done=%0d data=%h err=%0d want 2 %h 0",
               got.size(), rx_data, err_cnt - e0, exp_data);
    end
  endtask

  task automatic test_break;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    baud_set = 3'd4;
    drive_bit(1'b0, bit_cycles(3'd4) * 30);
    vectors++;
    if (err_cnt - e0 != 1 || done_cnt != d0 || uart_state !== 1'b0) begin
      miscompares++;
      $display("FAIL break_once: got err=%0d done=%0d state=%b want 1 0 0",
               err_cnt - e0, done_cnt - d0, uart_state);
    end
    idle(bit_cycles(3'd4) * 2);
    got.delete();
    send_frame(8'h96, 1'b1, 3'd4);
    idle(10);
    exp_data = 8'h96;
    vectors++;
    if (got.size() != 1 || rx_data !== exp_data || err_cnt - e0 != 1) begin
      miscompares++;
      $display("FAIL break_recover: got done=%0d data=%h err=%0d want 1 %h 1",
               got.size(), rx_data, err_cnt - e0, exp_data);
    end
  endtask

  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic [2:0] sel;
    logic       stop;
    logic       prev_bad;
    int e0, exp_err;
    e0 = err_cnt; exp_err = 0; prev_bad = 1'b0;
    got.delete();
    for (int k = 0; k < 16; k++) begin
      b    = 8'($urandom);
      sel  = 3'($urandom_range(1, 7));
      stop = ($urandom_range(0, 4) != 0);
      if (prev_bad) idle(bit_cycles(sel));
      else idle($urandom_range(0, 40));
      send_frame(b, stop, sel);
      if (stop) begin
        exp_q.push_back(b);
        exp_data = b;
      end else begin
        exp_err++;
      end
      prev_bad = ~stop;
    end
    idle(bit_cycles(3'd1));
    vectors++;
    if (got.size() != exp_q.size() || err_cnt - e0 != exp_err) begin
      miscompares++;
      $display("FAIL rand_counts: got done=%0d err=%0d want %0d %0d",
               got.size(), err_cnt - e0, exp_q.size(), exp_err);
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      vectors++;
      if (got[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand_byte%0d: got %h want %h", i, got[i], exp_q[i]);
      end
    end
    vectors++;
    if (rx_data !== exp_data || both_cnt != 0 || uart_state !== 1'b0) begin
      miscompares++;
      $display("FAIL rand_final: got data=%h both=%0d state=%b want %h 0 0",
               rx_data, both_cnt, uart_state, exp_data);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    done_cnt = 0; err_cnt = 0; both_cnt = 0;
    exp_data = 8'h00;
    sys_rst_n = 1'b0;
    uart_rx = 1'b1;
    baud_set = 3'd4;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_baud_change();
    test_break();
    test_random();
    vectors++;
    if (both_cnt != 0) begin
      miscompares++;
      $display("FAIL done_err_overlap: got %0d overlapping cycles want 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-002 sys_clk  input  1  system clock; all logic on rising edge.
REQ-003 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-004 baud_set  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4..7=115200.
REQ-005 uart_rx  input  1  serial line, idle high, 8N1, LSB first; asynchronous to sys_clk.
REQ-006 rx_data  output  8  last correctly received byte.
REQ-007 rx_done  output  1  one-cycle pulse; rx_data valid from that cycle on.
REQ-008 frame_err  output  1  one-cycle pulse when stop bit sampled low.
REQ-009 uart_state  output  1  high while a frame is in progress (start detected to end of stop sampling).

Function
REQ-010 uart_rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value; a third flop SHALL provide falling-edge detection.
REQ-011 Oversampling tick SHALL be generated at 16x baud: divider DIV = CLK_FREQ/(baud*16), integer floor; counter runs 0..DIV-1 and tick asserts when counter = DIV-1 (50 MHz: 325/162/81/54/27).
REQ-012 baud_set SHALL be latched on start-edge detection; changes during a frame SHALL have no effect until the next frame.
REQ-013 States: IDLE, START, DATA, STOP.
REQ-014 IDLE: divider and tick counter held at 0; synchronized falling edge -> START, uart_state=1.
REQ-015 Each bit spans 16 ticks (tick index 0..15); samples taken at tick indices 7, 8, 9; bit value = 2-of-3 majority.
REQ-016 START: majority 1 at tick 9 -> false start, return to IDLE, uart_state=0, no pulses; majority 0 -> continue to tick 15, then DATA.
REQ-017 DATA: 8 bits, bit n shifted into position n (LSB first); after bit 7 tick 15 -> STOP.
REQ-018 STOP: decision at tick 9 of stop bit (does not wait for ticks 10..15) so back-to-back frames with no idle are received.
REQ-019 Stop majority 1: rx_data <= shift register and rx_done=1 in the cycle following the tick-9 sample; majority 0: frame_err=1 in that cycle, rx_data unchanged.
REQ-020 After the STOP decision: -> IDLE, uart_state=0 in the same cycle as rx_done/frame_err; a falling edge is accepted from the next cycle.
REQ-021 rx_done and frame_err SHALL never assert together, and each is high for exactly one sys_clk cycle per frame.
REQ-022 A line held low (break) SHALL produce one frame_err, then the FSM stays in IDLE until a new falling edge is seen.

Reset
REQ-023 Asserting sys_rst_n low SHALL immediately force: rx_data=8'h00, rx_done=0, frame_err=0, uart_state=0, FSM=IDLE, all counters and the shift register cleared, synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait for a fresh falling edge, and no pulse is produced for the aborted frame.
REQ-025 Reset release SHALL be usable asynchronously; first active edge is the first rising sys_clk with sys_rst_n high.

Verification
REQ-026 baud_set=4, send 0x55 at 115200 -> single rx_done pulse, rx_data=0x55, frame_err never high.
REQ-027 baud_set=0, send 0xA3 then 0x0F back-to-back at 9600, zero idle between frames -> two rx_done pulses, rx_data=0xA3 then 0x0F.
REQ-028 Low glitch of 2 us on idle line at baud_set=4 -> no rx_done, no frame_err, uart_state back to 0 within 1 bit time.
REQ-029 Send 0x3C at 115200 with stop bit forced low -> frame_err pulse, no rx_done, rx_data keeps previous value.
REQ-030 Assert reset during bit 4 of 0xF0, release, send 0x81 -> only rx_done with rx_data=0x81.
REQ-031 Change baud_set 4->0 during bit 2 of 0x5A sent at 115200 -> rx_data=0x5A; next frame decoded at 9600.
